line_buf_packer: RTL and testbench
==================================

Name: line_buf_packer

Overview:
- Camera-side line buffer controller in the capture path; sits directly upstream of the 1024x32 single-port BSRAM block.
- Packs consecutive RGB565 pixels in pairs into 32-bit words and writes each captured line into one of two ping-pong banks in that RAM.
- Streams each completed line to the downstream consumer (frame-buffer writer) over a valid/ready interface.
- Arbitrates the single RAM port between camera writes and consumer reads.

Parameters:
- LINE_PIXELS, 640: pixels per line; must be even and ≤ 1024.
- BANK1_BASE, 512: word address of bank 1; bank 0 starts at word 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pix_valid  in  1  pixel strobe
- pix_data  in  16  RGB565 pixel
- pix_sol  in  1  start of line; qualified by pix_valid, marks the first pixel of a line
- sram_ce  out  1  RAM clock enable
- sram_oce  out  1  RAM output clock enable; constant 1 (bypass read mode)
- sram_wre  out  1  RAM write enable
- sram_ad  out  10  RAM word address
- sram_din  out  32  RAM write data
- sram_dout  in  32  RAM read data; valid one cycle after the read is issued
- line_ready  out  1  a full bank is pending or being read
- rd_valid  out  1  output word valid
- rd_data  out  32  output word; pixel 2k in [15:0], pixel 2k+1 in [31:16]
- rd_last  out  1  asserted with the final word of a line
- rd_ready  in  1  consumer accepts the word
- line_drop  out  1  one-cycle pulse when an incoming line is discarded
- overflow  out  1  sticky; cleared only by reset

Behaviour:
- Reset (reset_n=0 at a clk edge): clear all outputs except sram_oce, clear full[1:0], set wr_bank=rd_bank=0, set the pixel counter to 0 and the write state to WAIT_SOL, empty the FIFO, set the read FSM to R_IDLE.
- Write side states:
  - WAIT_SOL: ignore pixels until pix_valid & pix_sol.
  - On pix_sol:
    - If full[wr_bank]=1: enter DROP, pulse line_drop, set overflow.
    - Otherwise: enter FILL with pixel count 0, and that pixel is stored.
  - DROP: ignore pixels until the next pix_sol.
  - pix_sol while in FILL restarts the line in the same bank from count 0; the partial line is discarded and full is not set.
- Packing:
  - Even pixel is latched into the low half.
  - Odd pixel completes the word; a write is issued on the next cycle with sram_ce=1, sram_wre=1, sram_ad = bank base + count/2, and sram_din = {odd, even}.
- Line completion:
  - When pixel LINE_PIXELS-1 is packed: its write is issued, then full[wr_bank] is set in the same cycle as that write, wr_bank toggles, and the state returns to WAIT_SOL.
  - Pixels after completion and without pix_sol are ignored.
- Arbitration:
  - A write always wins the port.
  - A read is issued only in a cycle with no write pending, with sram_ce=1, sram_wre=0.
  - The pixel rate guarantees at most one write every 2 cycles.
- Read FSM states: R_IDLE, R_STREAM, R_DRAIN.
  - R_IDLE -> R_STREAM when full[rd_bank]=1.
  - In R_STREAM, a read issues when: no write, issued count < LINE_PIXELS/2, and FIFO occupancy + in-flight < 2.
  - sram_dout is captured into a 2-entry output FIFO one cycle after issue.
  - After the last read issues -> R_DRAIN.
  - When the word with rd_last is accepted (rd_valid & rd_ready): clear full[rd_bank], toggle rd_bank, go to R_IDLE.
- line_ready = full[rd_bank].
- rd_data and rd_last stay stable while rd_valid=1 and rd_ready=0.
- Word order is strictly ascending. There is no duplication or loss under any rd_ready pattern.
- Write and read never target the same bank: reads only a full bank, writes only a non-full bank.
- Reset mid-line or mid-read aborts everything; there is no partial output after reset.

Decomposition:
- Package line_buf_pkg holds:
  - write state enum {WAIT_SOL, FILL, DROP}
  - read state enum {R_IDLE, R_STREAM, R_DRAIN}
  - WORDS_PER_LINE = LINE_PIXELS/2
  - bank base address constants
- Sub-module line_buf_out_fifo: 2-entry FIFO with valid/ready, carrying {last, data[31:0]}.

Test Plan:
- Reset held 3 cycles -> all outputs 0 except sram_oce=1; line_ready=0; overflow=0.
- One line of 640 pixels, pix_data = index, pix_valid every 2 cycles, rd_ready=1 -> 320 writes to ad 0..319, first din 0x0001_0000; line_ready=1; then 320 words read with word k = {2k+1, 2k}, rd_last on word 319, line_ready=0 after it.
- Line 2 written at full rate (pix_valid every cycle) while line 1 streams -> bank 1 writes at ad 512..831, reads deferred in write cycles, both lines intact and in order.
- rd_ready driven by a pseudo-random pattern (~30% high) -> exact 320-word sequence, data held while stalled.
- Three lines with rd_ready=0 -> third line dropped, line_drop pulses once, overflow stays 1; draining yields lines 1 and 2 unchanged.
- pix_sol re-asserted at pixel 100, then 640 more pixels -> writes restart at ad 0; full set only after pixel 639 of the new line; read data equals the new line.

Source files
------------

// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared states, line geometry and bank map for the camera line buffer.
package line_buf_pkg;
  typedef enum logic [1:0] {WAIT_SOL, FILL, DROP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_STREAM, R_DRAIN} rd_state_e;
  localparam int LINE_PIXELS_DEF = 640;
  localparam int WORDS_PER_LINE = LINE_PIXELS_DEF / 2;
  localparam int BANK0_BASE = 0;
  localparam int BANK1_BASE_DEF = 512;
  function automatic logic [9:0] bank_base(input logic bank, input int bank1);
    return bank ? 10'(bank1) : 10'(BANK0_BASE);
  endfunction
endpackage

// File: rtl/line_buf_out_fifo.sv
// line_buf_out_fifo: 2-entry valid/ready FIFO carrying {last, data[31:0]}.
// Ports: clk, reset_n (sync, active low); push_i/push_data_i write side;
// valid_o/ready_i/data_o read side (head held stable until popped); occ_o entry count.
module line_buf_out_fifo (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  logic [32:0] push_data_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [32:0] data_o,
  output logic [1:0]  occ_o
);
  logic [32:0] mem_q [2];
  logic        wp_q, rp_q;
  logic [1:0]  cnt_q;
  logic        pop;
  assign valid_o = cnt_q != 2'd0;
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rp_q];
  assign occ_o   = cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= push_data_i;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/line_buf_packer.sv
// line_buf_packer: packs RGB565 pixel pairs into a ping-pong line buffer in a 1024x32 RAM and streams full lines out.
// Ports: clk, reset_n (sync, active low); pix_valid/pix_data/pix_sol camera input;
// sram_* single RAM port (write wins, reads fill the gaps); line_ready, rd_valid/rd_data/rd_last/rd_ready
// output stream; line_drop pulse when a line finds its bank still full; overflow sticky drop flag.
module line_buf_packer
  import line_buf_pkg::*;
#(
  parameter int LINE_PIXELS = LINE_PIXELS_DEF,
  parameter int BANK1_BASE  = BANK1_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        pix_sol,
  output logic        sram_ce,
  output logic        sram_oce,
  output logic        sram_wre,
  output logic [9:0]  sram_ad,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout,
  output logic        line_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic        line_drop,
  output logic        overflow
);
  localparam int NW = LINE_PIXELS / 2;
  localparam logic [9:0] LAST_PIX  = 10'(LINE_PIXELS - 1);
  localparam logic [9:0] LAST_WORD = 10'(NW - 1);
  localparam logic [9:0] NW_V      = 10'(NW);

  wr_state_e   wst_q;
  rd_state_e   rst_q;
  logic [9:0]  cnt_q, iss_q, wr_ad_q;
  logic [15:0] lo_q;
  logic [31:0] wr_din_q;
  logic        wr_pend_q, wr_last_q, wr_bank_q, rd_bank_q;
  logic        drop_q, ovf_q, infl_q, infl_last_q;
  logic [1:0]  full_q, full_d;
  logic        sol, eb, rd_issue, pop, done;
  logic [32:0] fifo_data;
  logic [1:0]  occ;

  // A line may start in the very cycle the previous line's final write retires;
  // the bank it lands in is then the one wr_bank is toggling to.
  always_comb begin
    sol      = pix_valid && pix_sol;
    eb       = (wr_pend_q && wr_last_q) ? ~wr_bank_q : wr_bank_q;
    rd_issue = rst_q == R_STREAM && !wr_pend_q && iss_q < NW_V &&
               (occ == 2'd0 || (occ == 2'd1 && !infl_q));
    pop      = rd_valid && rd_ready;
    done     = rst_q == R_DRAIN && pop && rd_last;
    full_d   = full_q;
    if (wr_pend_q && wr_last_q) full_d[wr_bank_q] = 1'b1;
    if (done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wst_q     <= WAIT_SOL;
      cnt_q     <= '0;
      lo_q      <= '0;
      wr_pend_q <= 1'b0;
      wr_last_q <= 1'b0;
      wr_ad_q   <= '0;
      wr_din_q  <= '0;
      wr_bank_q <= 1'b0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      full_q    <= full_d;
      wr_pend_q <= 1'b0;
      wr_last_q <= 1'b0;
      drop_q    <= 1'b0;
      if (wr_pend_q && wr_last_q) wr_bank_q <= ~wr_bank_q;
      if (sol) begin
        if (full_q[eb]) begin
          wst_q  <= DROP;
          drop_q <= 1'b1;
          ovf_q  <= 1'b1;
        end else begin
          wst_q <= FILL;
          cnt_q <= 10'd1;
          lo_q  <= pix_data;
        end
      end else if (pix_valid && wst_q == FILL) begin
        cnt_q <= cnt_q + 10'd1;
        if (!cnt_q[0]) lo_q <= pix_data;
        else begin
          wr_pend_q <= 1'b1;
          wr_last_q <= cnt_q == LAST_PIX;
          wr_ad_q   <= bank_base(wr_bank_q, BANK1_BASE) + {1'b0, cnt_q[9:1]};
          wr_din_q  <= {pix_data, lo_q};
          if (cnt_q == LAST_PIX) wst_q <= WAIT_SOL;
        end
      end
    end
  end

  // Reads are throttled so FIFO entries plus the read in flight never exceed two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_q       <= R_IDLE;
      rd_bank_q   <= 1'b0;
      iss_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue && iss_q == LAST_WORD;
      if (rst_q == R_IDLE && full_q[rd_bank_q]) begin
        rst_q <= R_STREAM;
        iss_q <= '0;
      end
      if (rd_issue) begin
        iss_q <= iss_q + 10'd1;
        if (iss_q == LAST_WORD) rst_q <= R_DRAIN;
      end
      if (done) begin
        rst_q     <= R_IDLE;
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  line_buf_out_fifo u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (infl_q),
    .push_data_i({infl_last_q, sram_dout}),
    .ready_i    (rd_ready),
    .valid_o    (rd_valid),
    .data_o     (fifo_data),
    .occ_o      (occ)
  );

  assign sram_ce    = wr_pend_q || rd_issue;
  assign sram_oce   = 1'b1;
  assign sram_wre   = wr_pend_q;
  assign sram_ad    = wr_pend_q ? wr_ad_q : bank_base(rd_bank_q, BANK1_BASE) + iss_q;
  assign sram_din   = wr_din_q;
  assign rd_data    = fifo_data[31:0];
  assign rd_last    = rd_valid && fifo_data[32];
  assign line_ready = full_q[rd_bank_q];
  assign line_drop  = drop_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_line_buf_packer.sv
// tb_line_buf_packer: directed bench for line_buf_packer with a RAM model and expected write/read queues.
module tb_line_buf_packer;
  logic        clk = 1'b0, reset_n = 1'b0, pix_valid = 1'b0, pix_sol = 1'b0, rd_ready = 1'b0;
  logic [15:0] pix_data = '0;
  logic        sram_ce, sram_oce, sram_wre, line_ready, rd_valid, rd_last, line_drop, overflow;
  logic [9:0]  sram_ad;
  logic [31:0] sram_din, sram_dout, rd_data;
  logic [31:0] mem [1024];
  logic [41:0] wr_q [$];
  logic [41:0] rd_q [$];
  int          checks = 0, errors = 0, extra_wr = 0, extra_rd = 0, drops = 0, rdy_mode = 0;
  bit          mon_en = 1'b0, wb = 1'b0;

  line_buf_packer dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data), .pix_sol(pix_sol),
    .sram_ce(sram_ce), .sram_oce(sram_oce), .sram_wre(sram_wre), .sram_ad(sram_ad),
    .sram_din(sram_din), .sram_dout(sram_dout), .line_ready(line_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready), .line_drop(line_drop),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (sram_ce) begin
      if (sram_wre) mem[sram_ad] <= sram_din;
      else sram_dout <= mem[sram_ad];
    end

  always @(posedge clk) begin
    #1;
    rd_ready = (rdy_mode == 2) ? ($urandom_range(0, 9) < 3) : (rdy_mode == 1);
  end

  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (mon_en) begin
      if (sram_ce && sram_wre) begin
        if (wr_q.size() > 0) chk("wr", {sram_ad, sram_din}, wr_q.pop_front());
        else extra_wr++;
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) extra_rd++;
        else if (rd_ready) chk("rd", {9'd0, rd_last, rd_data}, rd_q.pop_front());
        else chk("hold", {9'd0, rd_last, rd_data}, rd_q[0]);
      end
      if (line_drop) drops++;
    end

  task automatic send_line(input logic [15:0] base, input int n, input int gap, input bit keep);
    logic [15:0] lo;
    if (keep) begin
      for (int k = 0; k < n / 2; k++) begin
        lo = base + 16'(2 * k);
        wr_q.push_back({(wb ? 10'd512 : 10'd0) + 10'(k), lo + 16'd1, lo});
        if (n == 640) rd_q.push_back({9'd0, k == 319, lo + 16'd1, lo});
      end
      if (n == 640) wb = ~wb;
    end
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_sol   = i == 0;
      pix_data  = base + 16'(i);
      @(posedge clk); #1;
      if (gap > 1) begin
        pix_valid = 1'b0;
        pix_sol   = 1'b0;
        repeat (gap - 1) begin @(posedge clk); #1; end
      end
    end
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdq_left", 42'(rd_q.size()), 42'd0);
    chk("wrq_left", 42'(wr_q.size()), 42'd0);
    chk("extra_rd", 42'(extra_rd), 42'd0);
    chk("extra_wr", 42'(extra_wr), 42'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", 42'(sram_ce), 42'd0);
    chk("rst_oce", 42'(sram_oce), 42'd1);
    chk("rst_wre", 42'(sram_wre), 42'd0);
    chk("rst_ad", 42'(sram_ad), 42'd0);
    chk("rst_din", 42'(sram_din), 42'd0);
    chk("rst_valid", 42'(rd_valid), 42'd0);
    chk("rst_data", 42'(rd_data), 42'd0);
    chk("rst_last", 42'(rd_last), 42'd0);
    chk("rst_ready", 42'(line_ready), 42'd0);
    chk("rst_drop", 42'(line_drop), 42'd0);
    chk("rst_ovf", 42'(overflow), 42'd0);
    reset_n  = 1'b1;
    mon_en   = 1'b1;
    rdy_mode = 1;
    send_line(16'h0000, 640, 2, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ready_line1", 42'(line_ready), 42'd1);
    send_line(16'h8000, 640, 1, 1'b1);
    drain(4000);
    chk("ready_clr2", 42'(line_ready), 42'd0);
    rdy_mode = 2;
    send_line(16'h3000, 640, 2, 1'b1);
    drain(8000);
    chk("ready_clr3", 42'(line_ready), 42'd0);
    rdy_mode = 0;
    @(posedge clk); #1;
    send_line(16'h5000, 640, 2, 1'b1);
    send_line(16'h6000, 640, 2, 1'b1);
    chk("drop_none", 42'(drops), 42'd0);
    chk("ovf_none", 42'(overflow), 42'd0);
    send_line(16'h7000, 640, 2, 1'b0);
    chk("drop_once", 42'(drops), 42'd1);
    chk("ovf_set", 42'(overflow), 42'd1);
    chk("ready_full", 42'(line_ready), 42'd1);
    rdy_mode = 1;
    drain(4000);
    chk("ovf_sticky", 42'(overflow), 42'd1);
    chk("drop_total", 42'(drops), 42'd1);
    rdy_mode = 0;
    @(posedge clk); #1;
    send_line(16'h9000, 640, 2, 1'b1);
    send_line(16'hA000, 200, 2, 1'b1);
    chk("wrq_pre_rst", 42'(wr_q.size()), 42'd0);
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_rst_valid", 42'(rd_valid), 42'd0);
    chk("mid_rst_ready", 42'(line_ready), 42'd0);
    chk("mid_rst_ovf", 42'(overflow), 42'd0);
    chk("mid_rst_ce", 42'(sram_ce), 42'd0);
    rd_q.delete();
    wb       = 1'b0;
    reset_n  = 1'b1;
    rdy_mode = 1;
    send_line(16'h4000, 100, 2, 1'b1);
    chk("partial_ready", 42'(line_ready), 42'd0);
    send_line(16'hC000, 640, 2, 1'b1);
    drain(4000);
    chk("ready_end", 42'(line_ready), 42'd0);
    repeat (20) begin @(posedge clk); #1; end
    chk("extra_rd_end", 42'(extra_rd), 42'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
